// File: rtl/ps2_kbd_pkg.sv
// Shared scancode constants, prefix-FSM states and helpers for the PS/2 key translator.
package ps2_kbd_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;

    // Keys with special meaning to the translator
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_LAYOUT = 8'h0E;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    // The Pause key sends E1 followed by seven more bytes that carry no information
    localparam int PAUSE_SKIP = 7;
    localparam int SKIP_W     = $clog2(PAUSE_SKIP + 1);

    // Code emitted for the keypad Enter (E0 5A)
    localparam logic [15:0] CHAR_ENTER = 16'h000D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    // Keys that change translator state instead of producing a character
    function automatic logic is_modifier(input logic [7:0] sc);
        return (sc == SC_LSHIFT) || (sc == SC_RSHIFT) ||
               (sc == SC_CAPS)   || (sc == SC_LAYOUT);
    endfunction

endpackage

// File: rtl/keymap_rom.sv
// Keymap lookup table: registered address, combinational case table.
// Address = {layout, upper, scancode}; a zero word means the key is unmapped.
module keymap_rom #(
    parameter int DATA_W = 16,
    parameter int LSEL_W = 1
) (
    input  logic                i_clk,
    input  logic                i_addr_we,
    input  logic [LSEL_W+8:0]   i_addr,
    output logic [DATA_W-1:0]   o_data
);

    logic [LSEL_W+8:0] r_addr;
    logic [LSEL_W-1:0] w_layout;
    logic              w_upper;
    logic [7:0]        w_sc;
    logic [15:0]       w_word;

    // English: letters follow Shift/Caps, everything else is case-less
    function automatic logic [15:0] eng_word(input logic [7:0] sc, input logic upper);
        logic [7:0] ch;
        ch = 8'h00;
        case (sc)
            8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
            8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
            8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
            8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
            8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
            8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
            8'h35: ch = "y";  8'h1A: ch = "z";
            8'h45: ch = "0";  8'h16: ch = "1";  8'h1E: ch = "2";  8'h26: ch = "3";
            8'h25: ch = "4";  8'h2E: ch = "5";  8'h36: ch = "6";  8'h3D: ch = "7";
            8'h3E: ch = "8";  8'h46: ch = "9";
            8'h29: ch = 8'h20;
            8'h5A: ch = 8'h0D;
            8'h66: ch = 8'h08;
            default: ch = 8'h00;
        endcase
        if (upper && (ch >= "a") && (ch <= "z"))
            ch = ch - 8'h20;
        return {8'h00, ch};
    endfunction

    // Thai Kedmanee: full 16-bit code points, separate shifted plane
    function automatic logic [15:0] thai_word(input logic [7:0] sc, input logic upper);
        logic [15:0] w;
        case ({upper, sc})
            9'h016: w = 16'h0E45;  9'h01E: w = 16'h002F;  9'h026: w = 16'h002D;
            9'h025: w = 16'h0E20;  9'h02E: w = 16'h0E16;  9'h015: w = 16'h0E46;
            9'h01D: w = 16'h0E44;  9'h024: w = 16'h0E33;  9'h02D: w = 16'h0E1E;
            9'h02C: w = 16'h0E30;  9'h01C: w = 16'h0E1F;  9'h01B: w = 16'h0E2B;
            9'h023: w = 16'h0E01;  9'h02B: w = 16'h0E14;  9'h034: w = 16'h0E40;
            9'h042: w = 16'h0E32;  9'h04B: w = 16'h0E2A;  9'h01A: w = 16'h0E1C;
            9'h022: w = 16'h0E1B;  9'h021: w = 16'h0E41;  9'h02A: w = 16'h0E2D;
            9'h03A: w = 16'h0E17;  9'h029: w = 16'h0020;
            9'h116: w = 16'h002B;  9'h11C: w = 16'h0E24;  9'h11B: w = 16'h0E06;
            9'h123: w = 16'h0E0F;  9'h12B: w = 16'h0E42;  9'h134: w = 16'h0E0C;
            9'h142: w = 16'h0E29;  9'h129: w = 16'h0020;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Capture the lookup address when the translator starts a lookup
    // NOTE: no reset here -- the output is only consumed the cycle after a write.
    always_ff @(posedge i_clk) begin
        if (i_addr_we)
            r_addr <= i_addr;
    end

    assign w_layout = r_addr[LSEL_W+8:9];
    assign w_upper  = r_addr[8];
    assign w_sc     = r_addr[7:0];

    // Select the table for the active layout; unknown layouts read as unmapped
    // NOTE: w_word gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_word = 16'h0000;
        if (w_layout == LSEL_W'(0))
            w_word = eng_word(w_sc, w_upper);
        else if (w_layout == LSEL_W'(1))
            w_word = thai_word(w_sc, w_upper);
    end

    assign o_data = DATA_W'(w_word);

endmodule

// File: rtl/ps2_key_translator.sv
// PS/2 scancode to character translator: prefix FSM, modifier tracking and keymap lookup.
module ps2_key_translator
    import ps2_kbd_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int LAYOUTS = 2,
    parameter int LSEL_W  = (LAYOUTS > 1) ? $clog2(LAYOUTS) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_scan_valid,
    input  logic [7:0]        i_scan_data,
    output logic              o_scan_ready,
    output logic              o_char_valid,
    output logic [DATA_W-1:0] o_char_data,
    input  logic              i_char_ready,
    output logic [LSEL_W-1:0] o_layout,
    output logic              o_shift_held,
    output logic              o_caps_lock
);

    state_t            r_state, w_state_next;
    logic [SKIP_W-1:0] r_skip_cnt, w_skip_next;

    logic              r_lshift, r_rshift, r_caps_held, r_caps_lock;
    logic              r_layout_held;
    logic [LSEL_W-1:0] r_layout;

    logic              r_lookup_pending, r_enter_pending;
    logic              r_char_valid;
    logic [DATA_W-1:0] r_char_data;

    logic              w_accept, w_make, w_break, w_enter, w_lookup;
    logic [LSEL_W+8:0] w_rom_addr;
    logic [DATA_W-1:0] w_rom_data;

    assign o_scan_ready = ~i_reset & ~r_lookup_pending & ~r_char_valid;
    assign w_accept     = i_scan_valid & o_scan_ready;

    // Prefix state register and Pause skip counter
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_skip_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_skip_cnt <= w_skip_next;
        end
    end

    // Classify the accepted byte and choose the next prefix state
    always_comb begin
        w_state_next = r_state;
        w_skip_next  = r_skip_cnt;
        w_make       = 1'b0;
        w_break      = 1'b0;
        w_enter      = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (i_scan_data == SC_BRK)
                        w_state_next = S_BRK;
                    else if (i_scan_data == SC_EXT)
                        w_state_next = S_EXT;
                    else if (i_scan_data == SC_PAUSE) begin
                        w_state_next = S_PAUSE;
                        w_skip_next  = SKIP_W'(PAUSE_SKIP);
                    end else
                        w_make = 1'b1;
                end
                S_EXT: begin
                    if (i_scan_data == SC_BRK)
                        w_state_next = S_EXT_BRK;
                    else begin
                        w_enter      = (i_scan_data == SC_ENTER);
                        w_state_next = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    w_break      = 1'b1;
                    w_state_next = S_IDLE;
                end
                S_PAUSE: begin
                    w_skip_next = r_skip_cnt - SKIP_W'(1);
                    if (r_skip_cnt == SKIP_W'(1))
                        w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign w_lookup   = w_make & ~is_modifier(i_scan_data);
    assign w_rom_addr = {r_layout, (r_lshift | r_rshift) ^ r_caps_lock, i_scan_data};

    // Modifier tracking: Shift sides, Caps toggle-once-per-press, layout cycling
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lshift      <= 1'b0;
            r_rshift      <= 1'b0;
            r_caps_held   <= 1'b0;
            r_caps_lock   <= 1'b0;
            r_layout_held <= 1'b0;
            r_layout      <= '0;
        end else if (w_make) begin
            case (i_scan_data)
                SC_LSHIFT: r_lshift <= 1'b1;
                SC_RSHIFT: r_rshift <= 1'b1;
                SC_CAPS: begin
                    if (!r_caps_held)
                        r_caps_lock <= ~r_caps_lock;
                    r_caps_held <= 1'b1;
                end
                SC_LAYOUT: begin
                    if (!r_layout_held)
                        r_layout <= (r_layout == LSEL_W'(LAYOUTS - 1)) ? '0 : r_layout + LSEL_W'(1);
                    r_layout_held <= 1'b1;
                end
                default: ;
            endcase
        end else if (w_break) begin
            case (i_scan_data)
                SC_LSHIFT: r_lshift      <= 1'b0;
                SC_RSHIFT: r_rshift      <= 1'b0;
                SC_CAPS:   r_caps_held   <= 1'b0;
                SC_LAYOUT: r_layout_held <= 1'b0;
                default: ;
            endcase
        end
    end

    keymap_rom #(
        .DATA_W (DATA_W),
        .LSEL_W (LSEL_W)
    ) u_keymap_rom (
        .i_clk     (i_clk),
        .i_addr_we (w_lookup),
        .i_addr    (w_rom_addr),
        .o_data    (w_rom_data)
    );

    // Lookup pipeline and output character holding register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lookup_pending <= 1'b0;
            r_enter_pending  <= 1'b0;
            r_char_valid     <= 1'b0;
            r_char_data      <= '0;
        end else begin
            if (r_char_valid && i_char_ready)
                r_char_valid <= 1'b0;
            if (w_lookup || w_enter) begin
                r_lookup_pending <= 1'b1;
                r_enter_pending  <= w_enter;
            end else if (r_lookup_pending) begin
                r_lookup_pending <= 1'b0;
                if (r_enter_pending) begin
                    r_char_data  <= DATA_W'(CHAR_ENTER);
                    r_char_valid <= 1'b1;
                end else if (w_rom_data != '0) begin
                    r_char_data  <= w_rom_data;
                    r_char_valid <= 1'b1;
                end
            end
        end
    end

    assign o_char_valid = r_char_valid;
    assign o_char_data  = r_char_data;
    assign o_layout     = r_layout;
    assign o_shift_held = r_lshift | r_rshift;
    assign o_caps_lock  = r_caps_lock;

endmodule

// File: tb/tb_ps2_key_translator.sv
// Self-checking bench for ps2_key_translator: directed byte sequences, a key-level
// model producing the expected character stream, and literal checks on each scenario.
module tb_ps2_key_translator;

    localparam int DATA_W  = 16;
    localparam int LAYOUTS = 2;
    localparam int LSEL_W  = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              scan_valid = 1'b0;
    logic [7:0]        scan_data = 8'h00;
    logic              char_ready = 1'b0;
    logic              scan_ready;
    logic              char_valid;
    logic [DATA_W-1:0] char_data;
    logic [LSEL_W-1:0] layout;
    logic              shift_held;
    logic              caps_lock;

    always #5 clk = ~clk;

    ps2_key_translator #(
        .DATA_W  (DATA_W),
        .LAYOUTS (LAYOUTS),
        .LSEL_W  (LSEL_W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_scan_valid (scan_valid),
        .i_scan_data  (scan_data),
        .o_scan_ready (scan_ready),
        .o_char_valid (char_valid),
        .o_char_data  (char_data),
        .i_char_ready (char_ready),
        .o_layout     (layout),
        .o_shift_held (shift_held),
        .o_caps_lock  (caps_lock)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- key-level model ----------------
    logic [7:0]  eng_sc [0:25] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    bit          model_live = 1'b0;
    bit          m_brk, m_ext, m_ls, m_rs, m_caps, m_caps_down, m_lay_down;
    int          m_skip, m_layout;

    function automatic logic [15:0] model_char(input int lay, input bit up, input logic [7:0] sc);
        if (lay == 0) begin
            for (int i = 0; i < 26; i++)
                if (eng_sc[i] == sc)
                    return (up ? 16'h0041 : 16'h0061) + 16'(i);
        end else begin
            if (sc == 8'h16) return up ? 16'h002B : 16'h0E45;
            if (sc == 8'h1C) return up ? 16'h0E24 : 16'h0E1F;
        end
        return 16'h0000;
    endfunction

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_ls = 0; m_rs = 0; m_caps = 0;
        m_caps_down = 0; m_lay_down = 0; m_skip = 0; m_layout = 0;
        exp_q.delete();
        model_live = 1'b1;
    endtask

    task automatic model_accept(input logic [7:0] b);
        logic [15:0] c;
        if (m_skip > 0)
            m_skip--;
        else if (m_brk) begin
            m_brk = 0; m_ext = 0;
            if (b == 8'h12) m_ls = 0;
            if (b == 8'h59) m_rs = 0;
            if (b == 8'h58) m_caps_down = 0;
            if (b == 8'h0E) m_lay_down = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else begin
                m_ext = 0;
                if (b == 8'h5A) exp_q.push_back(16'h000D);
            end
        end else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'h12) m_ls = 1;
        else if (b == 8'h59) m_rs = 1;
        else if (b == 8'h58) begin
            if (!m_caps_down) m_caps = !m_caps;
            m_caps_down = 1;
        end else if (b == 8'h0E) begin
            if (!m_lay_down) m_layout = (m_layout + 1) % LAYOUTS;
            m_lay_down = 1;
        end else begin
            c = model_char(m_layout, (m_ls | m_rs) ^ m_caps, b);
            if (c != 16'h0000) exp_q.push_back(c);
        end
    endtask

    // Compare process: state outputs every cycle, characters on every handshake
    always @(negedge clk) begin
        if (model_live && !reset) begin
            check("layout", layout, m_layout);
            check("shift_held", shift_held, m_ls | m_rs);
            check("caps_lock", caps_lock, m_caps);
            if (char_valid && char_ready) begin
                got_q.push_back(char_data);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_char: got %h, expected none", char_data);
                end else
                    check("char_data", char_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- drivers (called at posedge + 1) ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        scan_valid = 1'b0;
        @(negedge clk);
        check("scan_ready_in_reset", scan_ready, 0);
        @(posedge clk);
        model_reset();
        #1 reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  ok;
        logic rdy;
        n = 0; ok = 0;
        scan_valid = 1'b1;
        scan_data  = b;
        while (!ok && n < 100) begin
            @(negedge clk);
            rdy = scan_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1;
                model_accept(b);
            end
            #1;
            n++;
        end
        scan_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: byte %h not accepted, expected acceptance", b);
        end
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || char_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    logic [7:0] seq[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- T1: reset values, single 'a', latency and back-pressure ----
        do_reset();
        @(negedge clk);
        check("rst_char_valid", char_valid, 0);
        check("rst_char_data", char_data, 0);
        check("rst_layout", layout, 0);
        check("rst_shift", shift_held, 0);
        check("rst_caps", caps_lock, 0);
        check("rst_scan_ready", scan_ready, 1);
        tick();
        got_q.delete();
        char_ready = 1'b0;
        send_byte(8'h1C);
        @(negedge clk);
        check("t1_valid_before", char_valid, 0);
        check("t1_ready_lookup", scan_ready, 0);
        tick();
        @(negedge clk);
        check("t1_valid_rise", char_valid, 1);
        check("t1_data", char_data, 16'h0061);
        tick();
        repeat (3) begin
            @(negedge clk);
            check("t1_hold_valid", char_valid, 1);
            check("t1_hold_data", char_data, 16'h0061);
            check("t1_hold_ready", scan_ready, 0);
            tick();
        end
        char_ready = 1'b1;
        drain();
        check("t1_count", got_q.size(), 1);
        check("t1_char", got_q[0], 16'h0061);

        // ---- T2: Shift make/break ----
        got_q.delete();
        send_byte(8'h12);
        @(negedge clk);
        check("t2_shift_on", shift_held, 1);
        tick();
        seq = '{8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
        send_seq(seq);
        drain();
        check("t2_shift_off", shift_held, 0);
        check("t2_count", got_q.size(), 2);
        check("t2_first", got_q[0], 16'h0041);
        check("t2_second", got_q[1], 16'h0061);

        // ---- T3: Caps Lock, Shift XOR Caps, typematic Caps ----
        got_q.delete();
        seq = '{8'h58, 8'hF0, 8'h58, 8'h1C};
        send_seq(seq);
        drain();
        check("t3_caps_on", caps_lock, 1);
        seq = '{8'h12, 8'h1C, 8'hF0, 8'h12};
        send_seq(seq);
        drain();
        seq = '{8'h58, 8'h58, 8'h58};
        send_seq(seq);
        drain();
        check("t3_caps_once", caps_lock, 0);
        seq = '{8'hF0, 8'h58, 8'h1C};
        send_seq(seq);
        drain();
        check("t3_count", got_q.size(), 3);
        check("t3_caps_A", got_q[0], 16'h0041);
        check("t3_shift_caps_a", got_q[1], 16'h0061);
        check("t3_plain_a", got_q[2], 16'h0061);

        // ---- T4: layout switching ----
        got_q.delete();
        seq = '{8'h0E, 8'hF0, 8'h0E, 8'h16};
        send_seq(seq);
        drain();
        check("t4_layout1", layout, 1);
        seq = '{8'h0E, 8'h0E, 8'hF0, 8'h0E, 8'h1C};
        send_seq(seq);
        drain();
        check("t4_layout_wrap", layout, 0);
        check("t4_count", got_q.size(), 2);
        check("t4_thai", got_q[0], 16'h0E45);
        check("t4_eng", got_q[1], 16'h0061);

        // ---- T5: Pause skip and extended codes ----
        got_q.delete();
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
        send_seq(seq);
        drain();
        check("t5_pause_count", got_q.size(), 1);
        seq = '{8'hE0, 8'h75, 8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'h1C};
        send_seq(seq);
        drain();
        check("t5_count", got_q.size(), 3);
        check("t5_pause_a", got_q[0], 16'h0061);
        check("t5_enter", got_q[1], 16'h000D);
        check("t5_after_ext", got_q[2], 16'h0061);

        // ---- T6: byte offered while a character is held ----
        got_q.delete();
        char_ready = 1'b0;
        send_byte(8'h1C);
        scan_valid = 1'b1;
        scan_data  = 8'h32;
        repeat (4) begin
            @(negedge clk);
            check("t6_blocked", scan_ready, 0);
            tick();
        end
        char_ready = 1'b1;
        send_byte(8'h32);
        drain();
        check("t6_count", got_q.size(), 2);
        check("t6_first", got_q[0], 16'h0061);
        check("t6_second", got_q[1], 16'h0062);

        // ---- T7: reset during a lookup ----
        got_q.delete();
        seq = '{8'h58, 8'hF0, 8'h58};
        send_seq(seq);
        drain();
        send_byte(8'h1C);
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t7_no_char", char_valid, 0);
            tick();
        end
        check("t7_caps_cleared", caps_lock, 0);
        send_byte(8'h1C);
        drain();
        check("t7_count", got_q.size(), 1);
        check("t7_char", got_q[0], 16'h0061);

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
